// File: rtl/sink_lookup_sched_if.sv
// Request/table/result bundle between the lookup engine (slave) and its users (master).
// Master drives requests and table writes; slave returns grant, busy and the registered verdict.
interface sink_lookup_sched_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 5
);
  logic                  tbl_we;
  logic [3:0]            tbl_waddr;
  logic [IDW-1:0]        tbl_wdata;
  logic                  tbl_clr;
  logic [NREQ-1:0]       req;
  logic [NREQ*IDW-1:0]   req_id;
  logic [NREQ-1:0]       grant;
  logic                  busy;
  logic                  done;
  logic                  iamSink;
  logic [3:0]            hit_index;

  modport master (
    output tbl_we, tbl_waddr, tbl_wdata, tbl_clr, req, req_id,
    input  grant, busy, done, iamSink, hit_index
  );

  modport slave (
    input  tbl_we, tbl_waddr, tbl_wdata, tbl_clr, req, req_id,
    output grant, busy, done, iamSink, hit_index
  );
endinterface

// File: rtl/sink_lookup_sched.sv
// Round-robin shared sink-table lookup: one requester at a time, linear scan with early exit.
// Hit at entry k reports done k+2 cycles after the request is taken, a miss ENTRIES+1; other requesters wait on req.
module sink_lookup_sched #(
  parameter int NREQ    = 4,
  parameter int ENTRIES = 10,
  parameter int IDW     = 5
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  sink_lookup_sched_if.slave lk
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int IW = $clog2(ENTRIES);

  typedef enum logic [1:0] {IDLE, SCAN, RESP} state_e;

  state_e              state_q;
  logic [PW-1:0]       ptr_q;
  logic [PW-1:0]       ptr_d;
  logic [IDW-1:0]      id_q;
  logic [IW-1:0]       idx_q;
  logic [NREQ-1:0]     grant_q;
  logic                busy_q;
  logic                done_q;
  logic                iamsink_q;
  logic [3:0]          hit_index_q;
  logic [ENTRIES-1:0]  vld_q;
  logic [IDW-1:0]      tbl_q [ENTRIES];

  logic [IDW-1:0]      rid [NREQ];
  logic                any_req;
  logic [PW-1:0]       win;
  logic [IDW-1:0]      win_id;
  logic [PW-1:0]       cand_w;
  int                  cand;
  logic                hit;
  logic                last;
  logic                wr_ok;

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign rid[g] = lk.req_id[g*IDW +: IDW];
  end

  // Walk from the farthest candidate back to ptr so the nearest requester wins.
  always_comb begin
    any_req = 1'b0;
    win     = '0;
    win_id  = '0;
    cand    = 0;
    cand_w  = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      cand   = (int'(ptr_q) + i) % NREQ;
      cand_w = PW'(cand);
      if (lk.req[cand_w]) begin
        any_req = 1'b1;
        win     = cand_w;
        win_id  = rid[cand_w];
      end
    end
  end

  assign ptr_d = (win == PW'(NREQ - 1)) ? '0 : win + PW'(1);

  assign hit   = vld_q[idx_q] && (tbl_q[idx_q] == id_q);
  assign last  = (idx_q == IW'(ENTRIES - 1));
  assign wr_ok = lk.tbl_we && !lk.tbl_clr && ({1'b0, lk.tbl_waddr} < 5'(ENTRIES));

  // Contents need no reset: an entry only counts once its valid bit is set.
  always_ff @(posedge clk_i) begin
    if (wr_ok) begin
      tbl_q[lk.tbl_waddr[IW-1:0]] <= lk.tbl_wdata;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q <= '0;
    end else if (lk.tbl_clr) begin
      vld_q <= '0;
    end else if (wr_ok) begin
      vld_q[lk.tbl_waddr[IW-1:0]] <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      idx_q       <= '0;
      grant_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      iamsink_q   <= 1'b0;
      hit_index_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (any_req) begin
            id_q    <= win_id;
            idx_q   <= '0;
            grant_q <= NREQ'(1) << win;
            busy_q  <= 1'b1;
            ptr_q   <= ptr_d;
            state_q <= SCAN;
          end
        end
        SCAN: begin
          if (hit || last) begin
            iamsink_q   <= hit;
            hit_index_q <= hit ? 4'(idx_q) : 4'd0;
            done_q      <= 1'b1;
            state_q     <= RESP;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        RESP: begin
          grant_q <= '0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign lk.grant     = grant_q;
  assign lk.busy      = busy_q;
  assign lk.done      = done_q;
  assign lk.iamSink   = iamsink_q;
  assign lk.hit_index = hit_index_q;

endmodule

// File: doc/sink_lookup_sched.md
# sink_lookup_sched

Shared sink-membership lookup engine with a round-robin scheduler. Up to NREQ requesters each present a node ID. The block grants one requester at a time and scans a locally held known-sinks table, one entry per cycle, exiting early on a match. It returns the iamSink verdict and the matching index with a single-cycle done pulse. It sits between the routing/cost-evaluation logic, which issues the requests, and the sink table that firmware loads.

## Interface
- NREQ, 4: number of requesters (2..8)
- ENTRIES, 10: known-sinks table depth (2..16)
- IDW, 5: node ID width
- clock  in  1  single system clock; all state updates on posedge
- reset  in  1  asynchronous, active-low; clears all state immediately
- tbl_we  in  1  write one table entry; sets its valid bit
- tbl_waddr  in  4  entry index; writes with index >= ENTRIES are ignored
- tbl_wdata  in  IDW  sink ID to store
- tbl_clr  in  1  clears all valid bits; contents are don't-care
- req  in  NREQ  per-requester lookup request, level
- req_id  in  NREQ*IDW  flattened IDs; requester r uses bits [r*IDW +: IDW]
- grant  out  NREQ  one-hot; high from the first SCAN cycle through the done cycle inclusive
- busy  out  1  high in SCAN and RESP
- done  out  1  one-cycle result strobe
- iamSink  out  1  1 = ID found in a valid entry; qualified by done
- hit_index  out  4  matching entry index on a hit; 0 on a miss; qualified by done

## Operation
- FSM states: IDLE, SCAN, RESP. Reset state is IDLE, and all outputs reset to 0.
- Reset clears all table valid bits and sets the round-robin pointer so that requester 0 has highest priority.
- IDLE:
  - If any req bit is set, select the first set bit at or after pointer, wrapping modulo NREQ.
  - Latch that requester's req_id, drive grant one-hot, set idx=0, go to SCAN.
  - Set pointer to (winner+1) mod NREQ.
- SCAN: each cycle, compare entry[idx] to the latched ID.
  - Hit = valid[idx] && equal. On a hit, record iamSink=1 and hit_index=idx, go to RESP.
  - Miss with idx==ENTRIES-1: record iamSink=0 and hit_index=0, go to RESP.
  - Otherwise idx++.
- RESP: done=1 for exactly one cycle, grant is held, then go to IDLE with grant cleared.
- Duplicate IDs in the table: the lowest matching index is reported.
- The latched ID is fixed for the whole scan. Changes on req_id, or the requester dropping req mid-scan, have no effect; the scan completes and done still pulses.
- Table writes are accepted in every state.
  - A write or clear to the entry being compared this cycle does not affect that compare; the old contents are used.
  - Entries already passed are not re-scanned.
  - tbl_clr and tbl_we in the same cycle: the clear wins and the write is dropped.
- iamSink and hit_index hold their last values outside done. Consumers must use them only when done=1.
- No combinational path from any input to any output. All outputs are registered.

## Timing
- Request sampled in IDLE at edge T, then grant and busy are high from cycle T+1. This is the first SCAN cycle, comparing entry 0.
- Hit at entry k: done is high in cycle T+2+k.
- Miss: done is high in cycle T+1+ENTRIES, which is T+11 at default.
- Back-to-back: after done, IDLE takes one cycle, so the next grant comes at the earliest 2 cycles after the previous done.
- Min per-lookup occupancy is 3 cycles (hit at entry 0). Max is ENTRIES+2.
- A requester holding req continuously is re-granted only after every other pending requester has been served once.
- Reset asserted mid-operation: grant, busy, done, iamSink and hit_index drop to 0 asynchronously. The table is invalidated. The first edge after reset deassertion is evaluated in IDLE.

## Test plan
- Load entries 0..9 with IDs 0..9 and have requester 0 ask for ID 3. Expect grant=0001 at T+1 and, at T+5, done=1, iamSink=1, hit_index=3. busy is low at T+6.
- Same table, requester 2 asks for ID 17. Expect done at T+11 with iamSink=0 and hit_index=0. Separately, tbl_clr then a request for ID 3 gives a miss.
- All four req held high with distinct IDs. Expect grant order 0,1,2,3,0. No grant overlaps, and exactly one done per grant.
- During a scan for ID 7, write entry 7 := 20 in the cycle entry 7 is compared. Expect a hit at index 7. Repeat the write 2 cycles earlier and expect a miss. Also write to tbl_waddr=12 and confirm no table change.
- Requester 1 asks for ID 4, drops req and changes req_id to 9 one cycle after grant. Expect the scan still reports a hit at index 4 and done pulses once.
- Assert reset at the 3rd SCAN cycle. All outputs are 0 immediately. After release, a request for ID 3 misses because the table is cleared, and the first grant goes to requester 0 when 0 and 3 request together.
